dm_access: RTL

- Memory-stage access controller: the initiator side of the data memory port (clk, addr, rd, wr, wdata, rdata).
- Turns pipeline load/store requests (word, halfword, byte; signed/unsigned loads) into word accesses on the 32-bit data memory.
- Sub-word stores run as a 2-cycle read-modify-write with a stall to the pipeline.
- Detects misaligned accesses and latches the faulting address.

---
 rtl/dm_pkg.sv | 50 +++++
 rtl/dm_access_if.sv | 27 ++
 rtl/dm_lane.sv | 65 ++++++
 rtl/dm_access.sv | 100 ++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: op codes, FSM states,
// byte-lane write masks and the alignment rule.
package dm_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RMW_WR = 1'b1;

  // Bit 3 of a lane mask selects word bits [31:24] (big-endian byte offset 0).
  localparam logic [3:0] LANE_NONE  = 4'b0000;
  localparam logic [3:0] LANE_WORD  = 4'b1111;
  localparam logic [3:0] LANE_HALF0 = 4'b1100;
  localparam logic [3:0] LANE_HALF2 = 4'b0011;
  localparam logic [3:0] LANE_BYTE0 = 4'b1000;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return op <= OP_LHU;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op_size(op))
      SZ_WORD: return off != 2'b00;
      SZ_HALF: return off[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_if.sv
// Word-wide data memory port: the access controller drives it (master), the
// memory answers with a combinational read word (slave).
interface dm_access_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_rd;
  logic              dm_wr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  modport master (
    output dm_addr,
    output dm_rd,
    output dm_wr,
    output dm_wdata,
    input  dm_rdata
  );

  modport slave (
    input  dm_addr,
    input  dm_rd,
    input  dm_wr,
    input  dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/dm_lane.sv
// Combinational lane logic: extracts and extends load results from a memory word
// and merges right-justified store data into the addressed big-endian lane(s).
module dm_lane
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  lane_mask;
  logic [31:0] rep_data;

  always_comb begin
    case (off)
      2'd0:    byte_v = word[31:24];
      2'd1:    byte_v = word[23:16];
      2'd2:    byte_v = word[15:8];
      default: byte_v = word[7:0];
    endcase
    half_v = off[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    ld_data = 32'd0;
    case (op)
      OP_LW:   ld_data = word;
      OP_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  ld_data = {24'd0, byte_v};
      OP_LH:   ld_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  ld_data = {16'd0, half_v};
      default: ld_data = 32'd0;
    endcase
  end

  // Store data is replicated across the word so every selected lane sees its bits.
  always_comb begin
    lane_mask = LANE_NONE;
    rep_data  = st_data;
    case (op)
      OP_SW: lane_mask = LANE_WORD;
      OP_SH: begin
        lane_mask = off[1] ? LANE_HALF2 : LANE_HALF0;
        rep_data  = {2{st_data[15:0]}};
      end
      OP_SB: begin
        lane_mask = LANE_BYTE0 >> off;
        rep_data  = {4{st_data[7:0]}};
      end
      default: lane_mask = LANE_NONE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = lane_mask[gi] ? rep_data[8*gi +: 8] : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dm_access.sv
// Memory-stage access controller: word/half/byte loads in one cycle, sub-word
// stores as a stalled read-modify-write, misalignment detection with sticky address.
module dm_access
  import dm_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W+1:0] baddr,
  input  logic [31:0]       st_data,
  output logic [31:0]       ld_data,
  output logic              stall,
  output logic              fault,
  output logic [ADDR_W+1:0] bad_addr,
  dm_access_if.master       mem
);

  logic [0:0]        state_reg, state_next;
  logic [31:0]       merge_reg, merge_next;
  logic [ADDR_W+1:0] bad_addr_reg, bad_addr_next;

  logic [31:0] lane_ld;
  logic [31:0] lane_merged;
  logic        rd_c, wr_c;
  logic [31:0] wdata_c;

  dm_lane u_lane (
    .op      (op),
    .off     (baddr[1:0]),
    .word    (mem.dm_rdata),
    .st_data (st_data),
    .ld_data (lane_ld),
    .merged  (lane_merged)
  );

  always_comb begin
    state_next    = state_reg;
    merge_next    = merge_reg;
    bad_addr_next = bad_addr_reg;
    rd_c          = 1'b0;
    wr_c          = 1'b0;
    wdata_c       = 32'd0;
    stall         = 1'b0;
    fault         = 1'b0;
    ld_data       = 32'd0;
    // Reset overrides everything so a pending RMW write is dropped.
    if (!rst) begin
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            if (misaligned(op, baddr[1:0])) begin
              fault         = 1'b1;
              bad_addr_next = baddr;
            end else if (is_load(op)) begin
              rd_c    = 1'b1;
              ld_data = lane_ld;
            end else if (op == OP_SW) begin
              wr_c    = 1'b1;
              wdata_c = st_data;
            end else begin
              // Read phase only; the write goes out next cycle so it never
              // collides with the write-through rdata bypass.
              rd_c       = 1'b1;
              stall      = 1'b1;
              merge_next = lane_merged;
              state_next = S_RMW_WR;
            end
          end
        end
        default: begin
          wr_c       = 1'b1;
          wdata_c    = merge_reg;
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      merge_reg    <= 32'd0;
      bad_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      merge_reg    <= merge_next;
      bad_addr_reg <= bad_addr_next;
    end
  end

  assign mem.dm_addr  = baddr[ADDR_W+1:2];
  assign mem.dm_rd    = rd_c;
  assign mem.dm_wr    = wr_c;
  assign mem.dm_wdata = wdata_c;
  assign bad_addr     = bad_addr_reg;

endmodule
